pipeline_buffer: RTL

Parametrised, multi-entry successor to the single-register pipeline deliver stage: a circular buffer that decouples a producing pipeline stage (e.g. PC generation) from its consumer (e.g. fetch). It accepts one word per cycle unless the producer stalls, holds up to DEPTH words while the consumer stalls, and presents the oldest word with a valid flag. Flush discards all contents in one cycle; full/empty/count outputs feed the pipeline stall controller.

---
 rtl/pipeline_buffer.sv | 98 +++++++++
 1 files changed

// File: rtl/pipeline_buffer.sv
// Circular pipeline buffer between a producing and a consuming stage.
// Optional same-cycle bypass when empty: define PIPE_BUFFER_BYPASS_EN.
module pipeline_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  stall_current_stage,
  input  logic                  stall_next_stage,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  count
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wp_q, wp_d;
  logic [PW-1:0]         rp_q, rp_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic push;
  logic byp;
  logic wr;
  logic rd;

  assign full  = (cnt_q == CNT_WIDTH'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  assign push = !stall_current_stage && !full && !flush;

`ifdef PIPE_BUFFER_BYPASS_EN
  assign byp = empty && push && !stall_next_stage;
`else
  assign byp = 1'b0;
`endif

  // A bypassed word is consumed directly and never occupies an entry.
  assign wr = push && !byp;
  assign rd = !empty && !stall_next_stage && !flush;

  assign out_valid = !empty || byp;

  always_comb begin
    data_out = '0;
    if (byp)
      data_out = data_in;
    else if (!empty)
      data_out = mem_q[rp_q];
  end

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (wr)
        wp_d = wp_q + 1'b1;
      if (rd)
        rp_d = rp_q + 1'b1;
      unique case ({wr, rd})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (wr)
      mem_q[wp_q] <= data_in;
  end

endmodule
